// File: rtl/bp_update_queue.sv
// rtl/bp_update_queue.sv - in-order prediction queue pairing resolved outcomes with predictor training (optional BPUQ_STATS_EN)
module bp_update_queue #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       pred_valid_i,
    input  logic [IDX_W-1:0]           pred_idx_i,
    input  logic                       pred_taken_i,
    output logic                       pred_ready_o,
    input  logic                       res_valid_i,
    input  logic                       res_taken_i,
    output logic                       res_ready_o,
    output logic                       update_en_o,
    output logic                       br_result_o,
    output logic [IDX_W-1:0]           idx_o,
    output logic                       correct_o,
`ifdef BPUQ_STATS_EN
    output logic [CNT_W-1:0]           total_o,
    output logic [CNT_W-1:0]           mispred_o,
    input  logic                       stats_clr_i,
`endif
    output logic [$clog2(DEPTH):0]     occupancy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [IDX_W-1:0] idx_mem [DEPTH];
    logic [DEPTH-1:0] taken_mem;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Extra pointer MSB tells a wrapped (full) queue apart from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign pred_ready_o = !full;
    assign res_ready_o  = !empty && !flush_i;
    assign occupancy_o  = wr_ptr - rd_ptr;

    assign push = pred_valid_i && pred_ready_o && !flush_i;
    assign pop  = res_valid_i && res_ready_o;

    always_ff @(posedge clk_i) begin
        if (push) begin
            idx_mem[wr_ptr[AW-1:0]]   <= pred_idx_i;
            taken_mem[wr_ptr[AW-1:0]] <= pred_taken_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            update_en_o <= 1'b0;
            br_result_o <= 1'b0;
            idx_o       <= '0;
            correct_o   <= 1'b0;
        end else begin
            update_en_o <= pop;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (pop) begin
                idx_o       <= idx_mem[rd_ptr[AW-1:0]];
                br_result_o <= res_taken_i;
                correct_o   <= (taken_mem[rd_ptr[AW-1:0]] == res_taken_i);
            end
        end
    end

`ifdef BPUQ_STATS_EN
    // Counters watch the registered training pulse, so they trail it by one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            total_o   <= '0;
            mispred_o <= '0;
        end else if (stats_clr_i) begin
            total_o   <= '0;
            mispred_o <= '0;
        end else if (update_en_o) begin
            if (total_o != '1) total_o <= total_o + CNT_W'(1);
            if (!correct_o && (mispred_o != '1)) mispred_o <= mispred_o + CNT_W'(1);
        end
    end
`endif

endmodule
